// File: rtl/vga_fb_arbiter_if.sv
// vga_fb_arbiter_if: line-fetch, pixel-writer and SRAM pin bundle for vga_fb_arbiter.
// The slave modport is the arbiter's view; master is the surrounding logic's view.
interface vga_fb_arbiter_if #(
  parameter int unsigned ADDR_W = 20,
  parameter int unsigned DATA_W = 16
) ();
  logic              i_line_req;
  logic [8:0]        i_line_y;
  logic              o_rd_valid;
  logic [DATA_W-1:0] o_rd_data;
  logic [9:0]        o_rd_x;
  logic              o_line_done;
  logic              o_line_overrun;
  logic              i_wr_valid;
  logic [ADDR_W-1:0] i_wr_addr;
  logic [DATA_W-1:0] i_wr_data;
  logic              o_wr_ready;
  logic              o_wr_err;
  logic [ADDR_W-1:0] o_sram_addr;
  logic [DATA_W-1:0] o_sram_wdata;
  logic              o_sram_we_n;
  logic              o_sram_oe_n;
  logic [DATA_W-1:0] i_sram_rdata;
  logic              o_busy;

  modport master (
    output i_line_req, i_line_y, i_wr_valid, i_wr_addr, i_wr_data, i_sram_rdata,
    input  o_rd_valid, o_rd_data, o_rd_x, o_line_done, o_line_overrun, o_wr_ready,
           o_wr_err, o_sram_addr, o_sram_wdata, o_sram_we_n, o_sram_oe_n, o_busy
  );

  modport slave (
    input  i_line_req, i_line_y, i_wr_valid, i_wr_addr, i_wr_data, i_sram_rdata,
    output o_rd_valid, o_rd_data, o_rd_x, o_line_done, o_line_overrun, o_wr_ready,
           o_wr_err, o_sram_addr, o_sram_wdata, o_sram_we_n, o_sram_oe_n, o_busy
  );
endinterface

// File: rtl/vga_fb_arbiter.sv
// vga_fb_arbiter: shares one 16-bit frame-buffer SRAM between VGA line prefetch bursts
// (H_ACT reads per line request) and a one-word-per-cycle pixel writer.
// Optional: define VGA_FB_WR_STARVE_GUARD_EN to insert a write slot into a read burst
// after STARVE_MAX consecutive read cycles with a writer waiting.
module vga_fb_arbiter #(
  parameter int unsigned H_ACT      = 640,
  parameter int unsigned V_ACT      = 480,
  parameter int unsigned ADDR_W     = 20,
  parameter int unsigned DATA_W     = 16,
  parameter int unsigned STARVE_MAX = 8
) (
  input logic             i_clk,
  input logic             i_rst,
  vga_fb_arbiter_if.slave bus
);

`ifdef VGA_FB_WR_STARVE_GUARD_EN
  localparam bit GuardEn = 1'b1;
`else
  localparam bit GuardEn = 1'b0;
`endif

  localparam int unsigned CW = $clog2(H_ACT + 1);
  localparam int unsigned SW = $clog2(STARVE_MAX + 1);
  localparam logic [ADDR_W-1:0] FrameWords = ADDR_W'(H_ACT * V_ACT);

  typedef enum logic [1:0] {StIdle, StWrite, StRead, StDrain} state_e;

  state_e            state_q;
  logic [ADDR_W-1:0] sram_addr_q;
  logic [DATA_W-1:0] sram_wdata_q;
  logic              sram_we_n_q;
  logic              sram_oe_n_q;
  logic [ADDR_W-1:0] rd_next_q;   // next read address to issue
  logic [CW-1:0]     rd_cnt_q;    // read addresses issued so far in this burst
  logic [9:0]        bus_x_q;     // column of the read address currently on the pins
  logic [SW-1:0]     starve_q;
  logic              rd_valid_q;
  logic [DATA_W-1:0] rd_data_q;
  logic [9:0]        rd_x_q;
  logic              line_done_q;
  logic              line_overrun_q;
  logic              wr_err_q;
  logic              busy_q;

  logic              can_take;
  logic              line_accept;
  logic              issue_done;
  logic              starve_slot;
  logic              wr_ready;
  logic              wr_fire;
  logic              wr_in_range;
  logic [ADDR_W-1:0] line_base;

  // Request decode, write-ready and the starvation write slot.
  always_comb begin
    can_take    = (state_q == StIdle) || (state_q == StWrite);
    line_accept = can_take && bus.i_line_req && (bus.i_line_y < 9'(V_ACT));
    issue_done  = (rd_cnt_q == CW'(H_ACT));
    starve_slot = GuardEn && (state_q == StRead) && (starve_q == SW'(STARVE_MAX)) &&
                  !issue_done;
    wr_ready    = (can_take && !bus.i_line_req) || starve_slot;
    wr_fire     = bus.i_wr_valid && wr_ready;
    wr_in_range = (bus.i_wr_addr < FrameWords);
    line_base   = ADDR_W'(bus.i_line_y) * ADDR_W'(H_ACT);
  end

  // Arbiter FSM with registered SRAM pins and read-return pipeline.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q        <= StIdle;
      sram_addr_q    <= '0;
      sram_wdata_q   <= '0;
      sram_we_n_q    <= 1'b1;
      sram_oe_n_q    <= 1'b1;
      rd_next_q      <= '0;
      rd_cnt_q       <= '0;
      bus_x_q        <= '0;
      starve_q       <= '0;
      rd_valid_q     <= 1'b0;
      rd_data_q      <= '0;
      rd_x_q         <= '0;
      line_done_q    <= 1'b0;
      line_overrun_q <= 1'b0;
      wr_err_q       <= 1'b0;
      busy_q         <= 1'b0;
    end else begin
      sram_we_n_q    <= 1'b1;
      sram_oe_n_q    <= 1'b1;
      wr_err_q       <= 1'b0;
      busy_q         <= 1'b0;
      line_overrun_q <= bus.i_line_req && !line_accept;
      // Asynchronous SRAM: data for the address on the pins is captured at this edge.
      rd_valid_q     <= !sram_oe_n_q;
      line_done_q    <= !sram_oe_n_q && (bus_x_q == 10'(H_ACT - 1));
      if (!sram_oe_n_q) begin
        rd_data_q <= bus.i_sram_rdata;
        rd_x_q    <= bus_x_q;
      end

      unique case (state_q)
        StIdle, StWrite: begin
          if (line_accept) begin
            state_q     <= StRead;
            busy_q      <= 1'b1;
            sram_addr_q <= line_base;
            sram_oe_n_q <= 1'b0;
            bus_x_q     <= '0;
            rd_next_q   <= line_base + ADDR_W'(1);
            rd_cnt_q    <= CW'(1);
            starve_q    <= '0;
          end else if (wr_fire) begin
            state_q <= StWrite;
          end else begin
            state_q <= StIdle;
          end
        end
        StRead: begin
          busy_q <= 1'b1;
          if (starve_slot) begin
            // Read address pauses this cycle; the write below takes the pins.
            starve_q <= '0;
          end else if (issue_done) begin
            state_q <= StDrain;
          end else begin
            sram_addr_q <= rd_next_q;
            sram_oe_n_q <= 1'b0;
            bus_x_q     <= 10'(rd_cnt_q);
            rd_next_q   <= rd_next_q + ADDR_W'(1);
            rd_cnt_q    <= rd_cnt_q + CW'(1);
            starve_q    <= (GuardEn && bus.i_wr_valid) ? starve_q + SW'(1) : '0;
          end
        end
        StDrain: begin
          state_q <= StIdle;
        end
        default: begin
          state_q <= StIdle;
        end
      endcase

      if (wr_fire) begin
        if (wr_in_range) begin
          sram_addr_q  <= bus.i_wr_addr;
          sram_wdata_q <= bus.i_wr_data;
          sram_we_n_q  <= 1'b0;
        end else begin
          wr_err_q <= 1'b1;
        end
      end
    end
  end

  assign bus.o_wr_ready     = wr_ready;
  assign bus.o_sram_addr    = sram_addr_q;
  assign bus.o_sram_wdata   = sram_wdata_q;
  assign bus.o_sram_we_n    = sram_we_n_q;
  assign bus.o_sram_oe_n    = sram_oe_n_q;
  assign bus.o_rd_valid     = rd_valid_q;
  assign bus.o_rd_data      = rd_data_q;
  assign bus.o_rd_x         = rd_x_q;
  assign bus.o_line_done    = line_done_q;
  assign bus.o_line_overrun = line_overrun_q;
  assign bus.o_wr_err       = wr_err_q;
  assign bus.o_busy         = busy_q;

endmodule

// File: tb/tb_vga_fb_arbiter.sv
// tb_vga_fb_arbiter: scoreboard bench for vga_fb_arbiter with an asynchronous SRAM model
// that returns addr[15:0] while output-enabled.
module tb_vga_fb_arbiter;
  localparam int H_ACT      = 640;
  localparam int V_ACT      = 480;
  localparam int STARVE_MAX = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   passed = 0;

  logic [25:0] rd_q[$];  // {x, data}
  logic [35:0] wr_q[$];  // {addr, data}

  vga_fb_arbiter_if #(.ADDR_W(20), .DATA_W(16)) bus ();

  vga_fb_arbiter #(
    .H_ACT(H_ACT), .V_ACT(V_ACT), .ADDR_W(20), .DATA_W(16), .STARVE_MAX(STARVE_MAX)
  ) dut (
    .i_clk(clk),
    .i_rst(rst),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  assign bus.i_sram_rdata = bus.o_sram_oe_n ? 16'h0000 : bus.o_sram_addr[15:0];

  task automatic test_reset();
    bus.i_line_req = 1'b0;
    bus.i_line_y   = '0;
    bus.i_wr_valid = 1'b0;
    bus.i_wr_addr  = '0;
    bus.i_wr_data  = '0;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if ({bus.o_rd_valid, bus.o_rd_data, bus.o_rd_x, bus.o_line_done, bus.o_line_overrun,
         bus.o_wr_err, bus.o_busy, bus.o_sram_addr, bus.o_sram_wdata} !== '0)
      $display("FAIL reset_zero_outputs: got rd_valid=%b x=%0d addr=%h busy=%b, want all 0",
               bus.o_rd_valid, bus.o_rd_x, bus.o_sram_addr, bus.o_busy);
    else passed++;
    rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      checks++;
      if ({bus.o_sram_we_n, bus.o_sram_oe_n} !== 2'b11)
        $display("FAIL reset_idle_pins: cycle %0d got we_n/oe_n=%b want 11", i,
                 {bus.o_sram_we_n, bus.o_sram_oe_n});
      else passed++;
    end
    checks++;
    if (bus.o_wr_ready !== 1'b1) $display("FAIL idle_wr_ready: got %b want 1", bus.o_wr_ready);
    else passed++;
  endtask

  task automatic test_write();
    logic [35:0] e;
    bus.i_wr_valid = 1'b1;
    bus.i_wr_addr  = 20'h00010;
    bus.i_wr_data  = 16'hBEEF;
    #1;
    checks++;
    if (bus.o_wr_ready !== 1'b1) $display("FAIL write_ready: got %b want 1", bus.o_wr_ready);
    else passed++;
    wr_q.push_back({bus.i_wr_addr, bus.i_wr_data});
    @(negedge clk);
    bus.i_wr_valid = 1'b0;
    e = wr_q.pop_front();
    checks++;
    if ({bus.o_sram_we_n, bus.o_sram_oe_n, bus.o_sram_addr, bus.o_sram_wdata} !== {2'b01, e})
      $display("FAIL single_write: got we_n=%b oe_n=%b addr=%h data=%h want we_n=0 oe_n=1 %h",
               bus.o_sram_we_n, bus.o_sram_oe_n, bus.o_sram_addr, bus.o_sram_wdata, e);
    else passed++;
    @(negedge clk);
    checks++;
    if ({bus.o_sram_we_n, bus.o_sram_addr} !== {1'b1, 20'h00010})
      $display("FAIL write_one_cycle: got we_n=%b addr=%h want we_n=1 addr=00010",
               bus.o_sram_we_n, bus.o_sram_addr);
    else passed++;
    // back-to-back writes, one per cycle
    for (int i = 0; i <= 4; i++) begin
      if (i > 0) begin
        e = wr_q.pop_front();
        checks++;
        if ({bus.o_sram_we_n, bus.o_sram_addr, bus.o_sram_wdata} !== {1'b0, e})
          $display("FAIL b2b_write_%0d: got we_n=%b addr=%h data=%h want we_n=0 %h", i,
                   bus.o_sram_we_n, bus.o_sram_addr, bus.o_sram_wdata, e);
        else passed++;
      end
      if (i < 4) begin
        bus.i_wr_valid = 1'b1;
        bus.i_wr_addr  = 20'h00200 + 20'(i);
        bus.i_wr_data  = 16'hC000 + 16'(i);
        wr_q.push_back({bus.i_wr_addr, bus.i_wr_data});
      end else begin
        bus.i_wr_valid = 1'b0;
      end
      @(negedge clk);
    end
    checks++;
    if (bus.o_sram_we_n !== 1'b1) $display("FAIL b2b_end: got we_n=%b want 1", bus.o_sram_we_n);
    else passed++;
  endtask

  task automatic test_wr_err();
    // last legal address, then first illegal one
    bus.i_wr_valid = 1'b1;
    bus.i_wr_addr  = 20'd307199;
    bus.i_wr_data  = 16'h1111;
    @(negedge clk);
    bus.i_wr_addr  = 20'd307200;
    bus.i_wr_data  = 16'h5555;
    checks++;
    if ({bus.o_sram_we_n, bus.o_wr_err, bus.o_sram_addr} !== {2'b00, 20'd307199})
      $display("FAIL last_addr_write: got we_n=%b err=%b addr=%h want 0 0 4afff",
               bus.o_sram_we_n, bus.o_wr_err, bus.o_sram_addr);
    else passed++;
    #1;
    checks++;
    if (bus.o_wr_ready !== 1'b1) $display("FAIL err_ready: got %b want 1", bus.o_wr_ready);
    else passed++;
    @(negedge clk);
    bus.i_wr_valid = 1'b0;
    checks++;
    if ({bus.o_sram_we_n, bus.o_wr_err, bus.o_sram_addr} !== {2'b11, 20'd307199})
      $display("FAIL oob_write: got we_n=%b err=%b addr=%h want we_n=1 err=1 addr=4afff",
               bus.o_sram_we_n, bus.o_wr_err, bus.o_sram_addr);
    else passed++;
    @(negedge clk);
    checks++;
    if (bus.o_wr_err !== 1'b0) $display("FAIL wr_err_pulse: got %b want 0", bus.o_wr_err);
    else passed++;
  endtask

  task automatic test_line_read();
    int          busy_n = 0;
    int          addr_n = 0;
    int          ovr_n = 0;
    int          first_valid = -1;
    logic [19:0] exp_addr = 20'd1280;
    logic [25:0] e;
    bus.i_line_req = 1'b1;
    bus.i_line_y   = 9'd2;
    for (int x = 0; x < H_ACT; x++) rd_q.push_back({10'(x), 16'(1280 + x)});
    @(negedge clk);
    bus.i_line_req = 1'b0;
    for (int i = 0; i < 800 && (rd_q.size() != 0 || bus.o_busy); i++) begin
      if (bus.o_busy) busy_n++;
      if (bus.o_line_overrun) ovr_n++;
      if (!bus.o_sram_oe_n) begin
        checks++;
        if (bus.o_sram_addr !== exp_addr)
          $display("FAIL read_addr: got %0d want %0d", bus.o_sram_addr, exp_addr);
        else passed++;
        exp_addr++;
        addr_n++;
      end
      if (bus.o_rd_valid) begin
        if (first_valid < 0) first_valid = i;
        checks++;
        if (rd_q.size() == 0) $display("FAIL extra_read: got x=%0d, want no read", bus.o_rd_x);
        else begin
          e = rd_q.pop_front();
          if ({bus.o_rd_x, bus.o_rd_data, bus.o_line_done} !== {e, e[25:16] == 10'(H_ACT - 1)})
            $display("FAIL read_word: got x=%0d data=%h done=%b want x=%0d data=%h", bus.o_rd_x,
                     bus.o_rd_data, bus.o_line_done, e[25:16], e[15:0]);
          else passed++;
        end
      end
      if (i == 101) begin
        checks++;
        if (bus.o_line_overrun !== 1'b1)
          $display("FAIL busy_overrun: got %b want 1", bus.o_line_overrun);
        else passed++;
      end
      bus.i_line_req = (i == 100);
      bus.i_line_y   = 9'd5;
      @(negedge clk);
    end
    checks++;
    if (rd_q.size() != 0) $display("FAIL read_timeout: got %0d words left want 0", rd_q.size());
    else passed++;
    rd_q.delete();
    checks++;
    if ({busy_n, addr_n, ovr_n, first_valid} !== {32'(H_ACT + 1), 32'(H_ACT), 32'd1, 32'd1})
      $display("FAIL burst_shape: got busy=%0d addrs=%0d overruns=%0d first_valid=%0d want %0d %0d 1 1",
               busy_n, addr_n, ovr_n, first_valid, H_ACT + 1, H_ACT);
    else passed++;
  endtask

  task automatic test_req_vs_write();
    int          busy_n = 0;
    int          n_in = 0;
    int          first_hs = -1;
    int          last_hs = -1;
    int          gap_bad = 0;
    int          post_hs = -1;
    bit          adv = 0;
    bit          stop = 0;
    logic [25:0] e;
    logic [35:0] w;
    bus.i_line_req = 1'b1;
    bus.i_line_y   = 9'd0;
    bus.i_wr_valid = 1'b1;
    bus.i_wr_addr  = 20'h00100;
    bus.i_wr_data  = 16'hA000;
    #1;
    checks++;
    if (bus.o_wr_ready !== 1'b0) $display("FAIL req_beats_write: got %b want 0", bus.o_wr_ready);
    else passed++;
    for (int x = 0; x < H_ACT; x++) rd_q.push_back({10'(x), 16'(x)});
    @(negedge clk);
    bus.i_line_req = 1'b0;
    for (int i = 0; i < 2000 && !(stop && wr_q.size() == 0 && rd_q.size() == 0); i++) begin
      if (adv) begin
        bus.i_wr_addr = bus.i_wr_addr + 20'd1;
        bus.i_wr_data = bus.i_wr_data + 16'd1;
        adv = 0;
      end
      if (stop) bus.i_wr_valid = 1'b0;
      #1;
      if (bus.o_busy) busy_n++;
      if (!bus.o_sram_we_n) begin
        checks++;
        if (wr_q.size() == 0) $display("FAIL unexpected_write: got addr %h want none", bus.o_sram_addr);
        else begin
          w = wr_q.pop_front();
          if ({bus.o_sram_addr, bus.o_sram_wdata} !== w)
            $display("FAIL arb_write: got %h/%h want %h", bus.o_sram_addr, bus.o_sram_wdata, w);
          else passed++;
        end
      end
      if (bus.o_rd_valid) begin
        checks++;
        if (rd_q.size() == 0) $display("FAIL extra_read2: got x=%0d want none", bus.o_rd_x);
        else begin
          e = rd_q.pop_front();
          if ({bus.o_rd_x, bus.o_rd_data} !== e)
            $display("FAIL arb_read: got x=%0d data=%h want x=%0d data=%h", bus.o_rd_x,
                     bus.o_rd_data, e[25:16], e[15:0]);
          else passed++;
        end
      end
      if (bus.i_wr_valid && bus.o_wr_ready) begin
        wr_q.push_back({bus.i_wr_addr, bus.i_wr_data});
        adv = 1;
        if (bus.o_busy) begin
          n_in++;
          if (last_hs >= 0 && i - last_hs != STARVE_MAX + 1) gap_bad++;
          if (first_hs < 0) first_hs = i;
          last_hs = i;
        end else begin
          post_hs = i;
          stop = 1;
        end
      end
      @(negedge clk);
    end
    bus.i_wr_valid = 1'b0;
    checks++;
    if ({stop, 32'(wr_q.size() + rd_q.size())} !== {1'b1, 32'd0})
      $display("FAIL arb_timeout: got stop=%b pending=%0d want 1 0", stop,
               wr_q.size() + rd_q.size());
    else passed++;
    wr_q.delete();
    rd_q.delete();
    checks++;
    if ({busy_n, post_hs} !== {32'(H_ACT + 1 + n_in), 32'(busy_n)})
      $display("FAIL arb_burst_len: got busy=%0d post_hs=%0d want busy=%0d post_hs=busy",
               busy_n, post_hs, H_ACT + 1 + n_in);
    else passed++;
`ifdef VGA_FB_WR_STARVE_GUARD_EN
    checks++;
    if (first_hs !== STARVE_MAX || gap_bad !== 0 || n_in < 1)
      $display("FAIL starve_slots: got first=%0d bad_gaps=%0d n=%0d want first=%0d 0 >0",
               first_hs, gap_bad, n_in, STARVE_MAX);
    else passed++;
`else
    checks++;
    if ({n_in, post_hs} !== {32'd0, 32'(H_ACT + 1)})
      $display("FAIL write_stall: got in_burst=%0d post_hs=%0d want 0 %0d", n_in, post_hs,
               H_ACT + 1);
    else passed++;
`endif
  endtask

  task automatic test_overrun_y();
    bus.i_line_req = 1'b1;
    bus.i_line_y   = 9'd480;
    @(negedge clk);
    bus.i_line_req = 1'b0;
    checks++;
    if ({bus.o_line_overrun, bus.o_busy, bus.o_sram_oe_n} !== 3'b101)
      $display("FAIL y_overrun: got ovr=%b busy=%b oe_n=%b want 1 0 1", bus.o_line_overrun,
               bus.o_busy, bus.o_sram_oe_n);
    else passed++;
    @(negedge clk);
    checks++;
    if ({bus.o_line_overrun, bus.o_busy} !== 2'b00)
      $display("FAIL y_overrun_pulse: got ovr=%b busy=%b want 0 0", bus.o_line_overrun,
               bus.o_busy);
    else passed++;
  endtask

  task automatic test_reset_mid_burst();
    bus.i_line_req = 1'b1;
    bus.i_line_y   = 9'd1;
    @(negedge clk);
    bus.i_line_req = 1'b0;
    repeat (20) @(negedge clk);
    checks++;
    if ({bus.o_busy, bus.o_rd_valid} !== 2'b11)
      $display("FAIL mid_burst_active: got busy=%b rd_valid=%b want 1 1", bus.o_busy,
               bus.o_rd_valid);
    else passed++;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      checks++;
      if ({bus.o_rd_valid, bus.o_line_done, bus.o_busy, bus.o_sram_oe_n, bus.o_sram_addr} !==
          {4'b0001, 20'd0})
        $display("FAIL abort_burst_%0d: got rd_valid=%b done=%b busy=%b oe_n=%b addr=%h want 0 0 0 1 0",
                 i, bus.o_rd_valid, bus.o_line_done, bus.o_busy, bus.o_sram_oe_n,
                 bus.o_sram_addr);
      else passed++;
      @(negedge clk);
    end
  endtask

  initial begin
    test_reset();
    test_write();
    test_wr_err();
    test_line_read();
    test_req_vs_write();
    test_overrun_y();
    test_reset_mid_burst();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/vga_fb_arbiter.md
Name: vga_fb_arbiter

Overview:
- Arbitrates the single-port 16-bit frame-buffer SRAM between two requesters: the VGA line prefetch (reads) and a pixel writer (writes).
- On each line request from the VGA timing side it streams one full active line (H_ACT words) out of SRAM into the line buffer.
- Between bursts it services writer transactions one word per cycle.
- Sits between the VGA timing/line buffer logic, the pixel producer, and the SRAM pins.

Parameters:
- H_ACT, 640, active pixels per line (words per burst)
- V_ACT, 480, active lines; frame size = H_ACT*V_ACT = 307200 words
- ADDR_W, 20, SRAM word-address width
- DATA_W, 16, SRAM data width
- STARVE_MAX, 8, consecutive read cycles before a forced write slot (optional feature only)

Ports:
- i_clk  in  1  pixel clock (25 MHz domain)
- i_rst  in  1  synchronous reset, active-high
- i_line_req  in  1  single-cycle pulse: fetch line i_line_y
- i_line_y  in  9  line index, 0..V_ACT-1
- o_rd_valid  out  1  o_rd_data/o_rd_x valid this cycle
- o_rd_data  out  DATA_W  pixel word read from SRAM
- o_rd_x  out  10  pixel column of o_rd_data, 0..H_ACT-1
- o_line_done  out  1  pulse coincident with the last o_rd_valid of a burst
- o_line_overrun  out  1  pulse: i_line_req dropped (burst busy or y out of range)
- i_wr_valid  in  1  writer request
- i_wr_addr  in  ADDR_W  write word address
- i_wr_data  in  DATA_W  write data
- o_wr_ready  out  1  write accepted when i_wr_valid & o_wr_ready
- o_wr_err  out  1  pulse: accepted write had address >= H_ACT*V_ACT and was dropped
- o_sram_addr  out  ADDR_W  registered SRAM address
- o_sram_wdata  out  DATA_W  registered SRAM write data
- o_sram_we_n  out  1  registered write enable, active-low
- o_sram_oe_n  out  1  registered output enable, active-low
- i_sram_rdata  in  DATA_W  SRAM read data, valid one cycle after its address is presented
- o_busy  out  1  high in S_READ or S_DRAIN

Behaviour:
- Clocking and reset:
  - One clock: i_clk.
  - Reset is synchronous, active-high (i_rst).
  - All outputs are registered except o_wr_ready.
- Reset values:
  - State = S_IDLE.
  - o_sram_we_n = 1, o_sram_oe_n = 1, o_sram_addr = 0, o_sram_wdata = 0.
  - o_rd_valid, o_rd_data, o_rd_x, o_line_done, o_line_overrun, o_wr_err, o_busy all 0.
- States: S_IDLE, S_WRITE, S_READ, S_DRAIN.
- Line request acceptance:
  - Accepted only in S_IDLE or S_WRITE with i_line_y < V_ACT.
  - Otherwise no burst starts and o_line_overrun pulses for 1 cycle on the next cycle.
- Priority: an accepted i_line_req beats a write in the same cycle.
  - o_wr_ready = (state is S_IDLE or S_WRITE) & ~i_line_req.
  - o_wr_ready is combinational.
- Read burst, request at cycle t:
  - Base address = y*H_ACT, computed in ADDR_W bits.
  - Cycles t+1 .. t+H_ACT: o_sram_addr = base+k for k = 0..H_ACT-1, with o_sram_oe_n = 0 and o_sram_we_n = 1.
  - Cycle t+2+k: o_rd_valid = 1, o_rd_data = i_sram_rdata (sampled), o_rd_x = k.
  - After the last address the FSM enters S_DRAIN for 1 cycle. There o_sram_oe_n = 1, and the last o_rd_valid fires with o_line_done = 1.
  - S_DRAIN then goes to S_IDLE.
  - Burst occupies exactly H_ACT+1 cycles.
- Write path:
  - On a handshake at cycle t, cycle t+1 has o_sram_addr = i_wr_addr, o_sram_wdata = i_wr_data, o_sram_we_n = 0 for exactly 1 cycle, o_sram_oe_n = 1.
  - Back-to-back writes give one write per cycle.
  - Out-of-range address (>= 307200): handshake still completes, o_sram_we_n stays 1, o_wr_err pulses at t+1.
- FSM transitions:
  - S_IDLE/S_WRITE → S_READ on an accepted line request.
  - Otherwise → S_WRITE on a handshake, else → S_IDLE.
- While no access is in progress: o_sram_we_n = 1, o_sram_oe_n = 1, and o_sram_addr holds its last value.
- Reset mid-burst: the burst is aborted immediately. No further o_rd_valid and no o_line_done.

Optional Feature:
- Macro: VGA_FB_WR_STARVE_GUARD_EN.
- When defined:
  - In S_READ, a counter counts consecutive read cycles while i_wr_valid = 1.
  - When the count reaches STARVE_MAX, o_wr_ready = 1 for one cycle and one write slot is inserted; the read address pauses that cycle.
  - The pause produces a one-cycle gap in o_rd_valid, and o_rd_x stays contiguous.
  - The counter then clears.
  - The burst lengthens by 1 cycle per inserted write.
- When undefined: o_wr_ready = 0 for the whole burst and writes stall.

Test Plan:
- Reset then idle: all outputs at reset values; o_sram_we_n = o_sram_oe_n = 1 for 10 cycles.
- Write addr 0x00010, data 0xBEEF with i_wr_valid held → handshake at t; at t+1 o_sram_addr = 0x00010, o_sram_wdata = 0xBEEF, o_sram_we_n = 0 for exactly 1 cycle.
- i_line_req with y = 2; SRAM model returns data = addr[15:0] → o_sram_addr runs 1280..1919; o_rd_x runs 0..639 with o_rd_data = 1280+x; o_line_done coincides with x = 639; o_busy high for 641 cycles.
- i_line_req and i_wr_valid in the same cycle → o_wr_ready = 0; the write completes on the first cycle after S_DRAIN.
- i_line_req during a burst, and i_line_req with y = 480 → o_line_overrun pulses once each; the current burst is unaffected.
- Write to addr 307200 → o_wr_err pulses and o_sram_we_n stays 1. With VGA_FB_WR_STARVE_GUARD_EN and a write pending during a burst → one write every STARVE_MAX+1 cycles; burst length = 641 + number of inserted writes.
